sccb_config_sequencer: RTL and testbench



---
 rtl/sccb_config_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer
//   Walks a fixed table of {subaddress, data} entries and issues one 3-phase
//   SCCB write per entry. Entries with subaddress FF are markers: {FF,FF} ends
//   the table, and {FF,n} waits n*DELAY_UNIT clocks (e.g. soft-reset settle).
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   i_start         one-cycle pulse, starts the table from entry 0 (IDLE only)
//   i_busy          SCCB master busy flag
//   o_usher         one-cycle launch strobe to the SCCB master
//   o_address       SCCB device write address (DEV_ADDR)
//   o_subaddress    register address of the current write entry
//   o_data          register value of the current write entry
//   o_mode          transfer mode, fixed 3-phase write
//   o_prescaler     SCL prescaler constant (PRESCALER)
//   o_running       sequence in progress
//   o_done          sticky, end of table reached
//   o_error         sticky, SCCB master never acknowledged a launch
//   o_index         current table index
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for i_start
// LOAD       | decode table entry at o_index
// ISSUE      | o_usher high, entry presented to SCCB master
// WAIT_ACK   | waiting for i_busy to rise, bounded by TIMEOUT
// WAIT_DONE  | waiting for i_busy to fall
// DELAY      | delay-marker wait
// DONE       | end of table, o_done set
// ERROR      | handshake timeout, o_error set

module sccb_config_sequencer #(
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter logic [15:0] PRESCALER  = 16'd4,
  parameter int          DELAY_UNIT = 100000,
  parameter int          TIMEOUT    = 1024,
  parameter int          ROM_DEPTH  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_busy,
  output logic                          o_usher,
  output logic [7:0]                    o_address,
  output logic [7:0]                    o_subaddress,
  output logic [7:0]                    o_data,
  output logic [1:0]                    o_mode,
  output logic [15:0]                   o_prescaler,
  output logic                          o_running,
  output logic                          o_done,
  output logic                          o_error,
  output logic [$clog2(ROM_DEPTH)-1:0]  o_index
);

  localparam int IDX_W = $clog2(ROM_DEPTH);
  // must hold 255*DELAY_UNIT
  localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [DLY_W-1:0] DU_C     = DLY_W'(DELAY_UNIT);
  // Down-counter equivalent of an up-count from 0 that errors on reaching
  // TIMEOUT-1: WAIT_ACK lasts at most TIMEOUT-1 cycles.
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         sub_q, data_q;
  logic [DLY_W-1:0]   dly_cnt_q, dly_load;
  logic [TO_W-1:0]    to_cnt_q;
  logic               done_q, error_q;

  logic [15:0]        rom_entry;
  logic               is_end, is_delay, is_write, dly_zero, is_last, advance;

  always_comb begin
    rom_entry = 16'hFFFF;
    case (idx_q)
      IDX_W'(0):  rom_entry = 16'h1280;   // COM7 soft reset
      IDX_W'(1):  rom_entry = 16'hFF0A;   // settle after soft reset
      IDX_W'(2):  rom_entry = 16'h1204;   // RGB output
      IDX_W'(3):  rom_entry = 16'h40D0;   // RGB565
      IDX_W'(4):  rom_entry = 16'h8C00;
      IDX_W'(5):  rom_entry = 16'h3A04;
      IDX_W'(6):  rom_entry = 16'h1438;
      IDX_W'(7):  rom_entry = 16'h4FB3;
      IDX_W'(8):  rom_entry = 16'hFF00;   // zero-length delay
      IDX_W'(9):  rom_entry = 16'h1713;
      IDX_W'(10): rom_entry = 16'h1801;
      IDX_W'(11): rom_entry = 16'hFFFF;
      default:    rom_entry = 16'hFFFF;
    endcase
  end

  always_comb begin
    is_end   = (rom_entry == 16'hFFFF);
    is_delay = (rom_entry[15:8] == 8'hFF) && !is_end;
    is_write = (rom_entry[15:8] != 8'hFF);
    dly_zero = (rom_entry[7:0] == 8'h00);
    is_last  = (idx_q == LAST_IDX);
    // n*DELAY_UNIT wait cycles in DELAY, so LOAD-to-LOAD is n*DELAY_UNIT+1
    dly_load = DLY_W'(rom_entry[7:0]) * DU_C - DLY_W'(1);
    advance  = ((state_q == S_LOAD) && is_delay && dly_zero) ||
               ((state_q == S_WAIT_DONE) && !i_busy) ||
               ((state_q == S_DELAY) && (dly_cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_start) state_d = S_LOAD;
      S_LOAD: begin
        if (is_end)                    state_d = S_DONE;
        else if (is_delay && !dly_zero) state_d = S_DELAY;
        else if (is_write)             state_d = S_ISSUE;
      end
      S_ISSUE:     state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        // a busy rise on the last allowed cycle still counts as success
        if (i_busy)                 state_d = S_WAIT_DONE;
        else if (to_cnt_q == '0)    state_d = S_ERROR;
      end
      S_WAIT_DONE, S_DELAY: ;
      S_DONE:      state_d = S_IDLE;
      S_ERROR:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // running off the end of the table is an implicit end marker
    if (advance) state_d = is_last ? S_DONE : S_LOAD;
  end

  always_comb begin
    o_usher   = (state_q == S_ISSUE);
    o_running = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE) ||
                (state_q == S_DELAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      sub_q     <= '0;
      data_q    <= '0;
      dly_cnt_q <= '0;
      to_cnt_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) idx_q <= '0;
        S_LOAD: begin
          // markers leave the SCCB-facing sub/data untouched
          if (is_write) begin
            sub_q  <= rom_entry[15:8];
            data_q <= rom_entry[7:0];
          end
          if (is_delay && !dly_zero) dly_cnt_q <= dly_load;
        end
        S_ISSUE:    to_cnt_q <= TO_LOAD;
        S_WAIT_ACK: if (to_cnt_q != '0) to_cnt_q <= to_cnt_q - 1'b1;
        S_DELAY:    if (dly_cnt_q != '0) dly_cnt_q <= dly_cnt_q - 1'b1;
        default: ;
      endcase

      if (advance && !is_last) idx_q <= idx_q + 1'b1;

      if ((state_q == S_IDLE) && i_start) begin
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        if (state_d == S_DONE)  done_q  <= 1'b1;
        if (state_d == S_ERROR) error_q <= 1'b1;
      end
    end
  end

  assign o_address    = DEV_ADDR;
  assign o_subaddress = sub_q;
  assign o_data       = data_q;
  assign o_mode       = 2'b00;
  assign o_prescaler  = PRESCALER;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_index      = idx_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
module tb_sccb_config_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_busy = 1'b0;
  logic        o_usher;
  logic [7:0]  o_address, o_subaddress, o_data;
  logic [1:0]  o_mode;
  logic [15:0] o_prescaler;
  logic        o_running, o_done, o_error;
  logic [5:0]  o_index;

  always #5 clk = ~clk;

  sccb_config_sequencer #(
    .DEV_ADDR(8'h42), .PRESCALER(16'd4), .DELAY_UNIT(10),
    .TIMEOUT(16), .ROM_DEPTH(64)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_busy(i_busy),
    .o_usher(o_usher), .o_address(o_address), .o_subaddress(o_subaddress),
    .o_data(o_data), .o_mode(o_mode), .o_prescaler(o_prescaler),
    .o_running(o_running), .o_done(o_done), .o_error(o_error),
    .o_index(o_index)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SCCB master model: busy high from 2 cycles after o_usher for 50 cycles
  // (mode 0), or never busy (mode 1). It ignores rst, like the real master.
  int         mode = 0;
  int         t = 1000;
  int         n_ush = 0;
  int         overlap = 0;
  logic [7:0] log_sub [64];
  logic [7:0] log_data [64];
  int         log_cyc [64];

  always @(negedge clk) begin
    if (o_usher === 1'b1) begin
      if (mode == 0 && t < 52) overlap++;
      if (n_ush < 64) begin
        log_sub[n_ush]  = o_subaddress;
        log_data[n_ush] = o_data;
        log_cyc[n_ush]  = cyc;
      end
      n_ush++;
      t = (mode == 0) ? 0 : 1000;
    end else if (t < 1000) begin
      t++;
    end
    i_busy = (t >= 2) && (t < 52);
  end

  logic [7:0] exp_sub  [9] = '{8'h12, 8'h12, 8'h40, 8'h8C, 8'h3A, 8'h14, 8'h4F, 8'h17, 8'h18};
  logic [7:0] exp_data [9] = '{8'h80, 8'h04, 8'hD0, 8'h00, 8'h04, 8'h38, 8'hB3, 8'h13, 8'h01};

  initial begin
    int base, c1, c2, cd, cu, ce;
    bit seen, got_ush;

    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_usher",   o_usher, 0);
    check_eq("rst_running", o_running, 0);
    check_eq("rst_done",    o_done, 0);
    check_eq("rst_error",   o_error, 0);
    check_eq("rst_index",   o_index, 0);
    check_eq("rst_sub",     o_subaddress, 0);
    check_eq("rst_data",    o_data, 0);
    check_eq("rst_mode",    o_mode, 0);
    check_eq("rst_address", o_address, 8'h42);
    check_eq("rst_presc",   o_prescaler, 16'd4);
    check_eq("rst_no_usher", n_ush, 0);

    // full table run
    base = n_ush;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("a_load_running", o_running, 1);
    check_eq("a_load_usher",   o_usher, 0);
    @(negedge clk);
    check_eq("a_first_usher", o_usher, 1);
    check_eq("a_first_sub",   o_subaddress, 8'h12);
    check_eq("a_first_data",  o_data, 8'h80);
    c1 = -1; c2 = -1; cd = -1; seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      i_start = (k == 10);            // ignored while running
      if (o_index == 6'd1 && c1 < 0) c1 = cyc;
      if (o_index == 6'd2 && c2 < 0) c2 = cyc;
      if (o_done) begin seen = 1; cd = cyc; break; end
    end
    check_eq("a_done_seen", seen, 1);
    i_start = 1'b1;                   // lands on the DONE cycle: ignored
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("a_done_sticky", o_done, 1);
    check_eq("a_running_off", o_running, 0);
    check_eq("a_error",       o_error, 0);
    check_eq("a_usher_count", n_ush - base, 9);
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("a_sub%0d", i),  log_sub[base + i],  exp_sub[i]);
      check_eq($sformatf("a_data%0d", i), log_data[base + i], exp_data[i]);
    end
    check_eq("a_delay_load_to_load", c2 - c1, 101);
    check_eq("a_issue_after_delay",  log_cyc[base + 1] - c2, 1);
    check_eq("a_gap_e0_e2",          log_cyc[base + 1] - log_cyc[base], 155);
    check_eq("a_gap_e2_e3",          log_cyc[base + 2] - log_cyc[base + 1], 54);
    check_eq("a_gap_zero_delay",     log_cyc[base + 7] - log_cyc[base + 6], 55);
    check_eq("a_done_latency",       cd - log_cyc[base + 8], 54);

    // busy never rises: timeout
    mode = 1;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("b_done_cleared", o_done, 0);
    check_eq("b_running",      o_running, 1);
    cu = -1; ce = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_usher) begin cu = cyc; break; end
    end
    check_eq("b_usher_seen", cu >= 0, 1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_error) begin ce = cyc; break; end
    end
    check_eq("b_error_latency", ce - cu, 16);
    check_eq("b_done",          o_done, 0);
    check_eq("b_running_off",   o_running, 0);
    repeat (3) @(negedge clk);
    check_eq("b_error_sticky",  o_error, 1);

    // restart after error, then reset mid-transfer of entry 3
    mode = 0;
    repeat (2) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("c_error_cleared", o_error, 0);
    check_eq("c_index0",        o_index, 0);
    @(negedge clk);
    check_eq("c_usher", o_usher, 1);
    check_eq("c_sub",   o_subaddress, 8'h12);
    check_eq("c_data",  o_data, 8'h80);
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (o_usher && o_index == 6'd3) begin seen = 1; break; end
    end
    check_eq("c_entry3_seen", seen, 1);
    check_eq("c_entry3_sub",  o_subaddress, 8'h40);
    check_eq("c_entry3_data", o_data, 8'hD0);
    repeat (10) @(negedge clk);
    check_eq("c_running_pre_rst", o_running, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("c_rst_index",   o_index, 0);
    check_eq("c_rst_running", o_running, 0);
    check_eq("c_rst_usher",   o_usher, 0);
    got_ush = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_usher) got_ush = 1;
    end
    check_eq("c_no_usher_after_rst", got_ush, 0);
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!i_busy) begin seen = 1; break; end
    end
    check_eq("c_busy_released", seen, 1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    check_eq("c_reissue_usher", o_usher, 1);
    check_eq("c_reissue_sub",   o_subaddress, 8'h12);
    check_eq("c_reissue_data",  o_data, 8'h80);
    check_eq("c_reissue_index", o_index, 0);
    repeat (5) @(negedge clk);
    check_eq("overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
